// File: rtl/mem_arbiter.sv
// Four-way memory arbiter: fixed priority ctx > mem > heap > if, with starvation relief for if.
// Drives one outstanding bus transaction at a time and pulses the owner's done on completion.
module mem_arbiter #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ctx_req_i,
    input  logic              ctx_we_i,
    input  logic [XLEN-1:0]   ctx_addr_i,
    input  logic [XLEN-1:0]   ctx_wdata_i,
    input  logic [XLEN/8-1:0] ctx_wstrb_i,

    input  logic              heap_req_i,
    input  logic              heap_we_i,
    input  logic [XLEN-1:0]   heap_addr_i,
    input  logic [XLEN-1:0]   heap_wdata_i,
    input  logic [XLEN/8-1:0] heap_wstrb_i,

    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [XLEN-1:0]   mem_addr_i,
    input  logic [XLEN-1:0]   mem_wdata_i,
    input  logic [XLEN/8-1:0] mem_wstrb_i,

    input  logic              if_req_i,
    input  logic              if_we_i,
    input  logic [XLEN-1:0]   if_addr_i,
    input  logic [XLEN-1:0]   if_wdata_i,
    input  logic [XLEN/8-1:0] if_wstrb_i,

    output logic              ctx_done_o,
    output logic              heap_done_o,
    output logic              mem_done_o,
    output logic              if_done_o,
    output logic [XLEN-1:0]   rdata_o,
    output logic              err_o,

    output logic              bus_valid_o,
    output logic              bus_we_o,
    output logic [XLEN-1:0]   bus_addr_o,
    output logic [XLEN-1:0]   bus_wdata_o,
    output logic [XLEN/8-1:0] bus_wstrb_o,
    input  logic              bus_ready_i,
    input  logic              bus_rvalid_i,
    input  logic [XLEN-1:0]   bus_rdata_i,
    input  logic              bus_err_i,

    input  logic              flushif_i,

    output logic              memstall_o,
    output logic              heapstall_o,
    output logic              ctxstall_o,
    output logic              ifstall_o
);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;
    typedef enum logic [1:0] {OwnCtx, OwnMem, OwnHeap, OwnIf} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              grant;
    logic                we_q, we_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [XLEN/8-1:0]   wstrb_q, wstrb_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [3:0]          starve_q, starve_d;
    logic                drop_q, drop_d;

    logic                sel_we;
    logic [XLEN-1:0]     sel_addr;
    logic [XLEN-1:0]     sel_wdata;
    logic [XLEN/8-1:0]   sel_wstrb;
    logic                any_req;

    assign any_req = ctx_req_i | mem_req_i | heap_req_i | if_req_i;

    // A saturated starve count lets the fetch requester jump the priority order once.
    always_comb begin
        grant = OwnIf;
        if (starve_q == 4'd15 && if_req_i) grant = OwnIf;
        else if (ctx_req_i)                grant = OwnCtx;
        else if (mem_req_i)                grant = OwnMem;
        else if (heap_req_i)               grant = OwnHeap;
        else                               grant = OwnIf;
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        unique case (grant)
            OwnCtx: begin
                sel_we = ctx_we_i;   sel_addr = ctx_addr_i;
                sel_wdata = ctx_wdata_i; sel_wstrb = ctx_wstrb_i;
            end
            OwnMem: begin
                sel_we = mem_we_i;   sel_addr = mem_addr_i;
                sel_wdata = mem_wdata_i; sel_wstrb = mem_wstrb_i;
            end
            OwnHeap: begin
                sel_we = heap_we_i;  sel_addr = heap_addr_i;
                sel_wdata = heap_wdata_i; sel_wstrb = heap_wstrb_i;
            end
            OwnIf: begin
                sel_we = if_we_i;    sel_addr = if_addr_i;
                sel_wdata = if_wdata_i; sel_wstrb = if_wstrb_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        starve_d = starve_q;
        drop_d   = drop_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    owner_d = grant;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    wstrb_d = sel_wstrb;
                    if (grant == OwnIf)                      starve_d = '0;
                    else if (if_req_i && starve_q != 4'd15)  starve_d = starve_q + 4'd1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (owner_q == OwnIf && flushif_i) drop_d = 1'b1;
                if (bus_ready_i) state_d = StResp;
            end
            StResp: begin
                if (owner_q == OwnIf && flushif_i) drop_d = 1'b1;
                if (bus_rvalid_i) begin
                    rdata_d = bus_err_i ? '0 : bus_rdata_i;
                    err_d   = bus_err_i;
                    state_d = StDone;
                end
            end
            StDone: begin
                drop_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            owner_q  <= OwnCtx;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            starve_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            starve_q <= starve_d;
            drop_q   <= drop_d;
        end
    end

    assign bus_valid_o = (state_q == StReq);
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign bus_wstrb_o = wstrb_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;

    assign ctx_done_o  = (state_q == StDone) && (owner_q == OwnCtx);
    assign mem_done_o  = (state_q == StDone) && (owner_q == OwnMem);
    assign heap_done_o = (state_q == StDone) && (owner_q == OwnHeap);
    assign if_done_o   = (state_q == StDone) && (owner_q == OwnIf) && !drop_q;

    assign ctxstall_o  = ctx_req_i  & ~ctx_done_o;
    assign memstall_o  = mem_req_i  & ~mem_done_o;
    assign heapstall_o = heap_req_i & ~heap_done_o;
    assign ifstall_o   = if_req_i   & ~if_done_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Requester index order everywhere: 0 ctx, 1 mem, 2 heap, 3 if.
module tb_mem_arbiter;

    localparam int CTX = 0, MEM = 1, HEAP = 2, IFR = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [4];
    logic        we    [4];
    logic [31:0] addr  [4];
    logic [31:0] wdata [4];
    logic [3:0]  wstrb [4];
    logic        bus_ready, bus_rvalid, bus_err, flushif;
    logic [31:0] bus_rdata;

    logic        ctx_done, heap_done, mem_done, if_done, err_o, bus_valid, bus_we;
    logic        memstall, heapstall, ctxstall, ifstall;
    logic [31:0] rdata_o, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [3:0]  done_v, stall_v;

    int checks = 0;
    int errors = 0;

    assign done_v  = {if_done, heap_done, mem_done, ctx_done};
    assign stall_v = {ifstall, heapstall, memstall, ctxstall};

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .ctx_req_i(req[CTX]), .ctx_we_i(we[CTX]), .ctx_addr_i(addr[CTX]),
        .ctx_wdata_i(wdata[CTX]), .ctx_wstrb_i(wstrb[CTX]),
        .heap_req_i(req[HEAP]), .heap_we_i(we[HEAP]), .heap_addr_i(addr[HEAP]),
        .heap_wdata_i(wdata[HEAP]), .heap_wstrb_i(wstrb[HEAP]),
        .mem_req_i(req[MEM]), .mem_we_i(we[MEM]), .mem_addr_i(addr[MEM]),
        .mem_wdata_i(wdata[MEM]), .mem_wstrb_i(wstrb[MEM]),
        .if_req_i(req[IFR]), .if_we_i(we[IFR]), .if_addr_i(addr[IFR]),
        .if_wdata_i(wdata[IFR]), .if_wstrb_i(wstrb[IFR]),
        .ctx_done_o(ctx_done), .heap_done_o(heap_done), .mem_done_o(mem_done),
        .if_done_o(if_done), .rdata_o(rdata_o), .err_o(err_o),
        .bus_valid_o(bus_valid), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_wstrb_o(bus_wstrb),
        .bus_ready_i(bus_ready), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata),
        .bus_err_i(bus_err), .flushif_i(flushif),
        .memstall_o(memstall), .heapstall_o(heapstall), .ctxstall_o(ctxstall),
        .ifstall_o(ifstall)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 4; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; wdata[i] = '0; wstrb[i] = '0;
            addr[i] = 32'h1000_0000 + 32'(i) * 32'h100;
        end
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = '0; flushif = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Drives one transaction with zero-wait bus from the current IDLE cycle; only collects outputs.
    task automatic run_txn(input int drop_id, input logic [31:0] rd, input logic e,
                           output logic [31:0] addr_obs, output logic [3:0] done_obs,
                           output logic [31:0] rdata_obs, output logic err_obs);
        step();
        #1 addr_obs = bus_addr;
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = rd; bus_err = e;
        step();
        bus_rvalid = 1'b0; bus_err = 1'b0; req[drop_id] = 1'b0;
        #1 done_obs = done_v; rdata_obs = rdata_o; err_obs = err_o;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1; step(); rst = 1'b0;
        req[MEM] = 1'b1; we[MEM] = 1'b1; addr[MEM] = 32'hCAFE_0004;
        wdata[MEM] = 32'h5555_AAAA; wstrb[MEM] = 4'hF;
        step();
        req[MEM] = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus_valid); end
        checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", bus_addr); end
        checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", bus_we); end
        checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", bus_wdata); end
        checks++; if (bus_wstrb !== 4'h0) begin errors++; $display("FAIL reset_wstrb got=%h exp=0", bus_wstrb); end
        checks++; if (done_v !== 4'h0) begin errors++; $display("FAIL reset_done got=%b exp=0000", done_v); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_o); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
    endtask

    task automatic test_single_read();
        apply_reset();
        req[MEM] = 1'b1; addr[MEM] = 32'h8000_0010;
        #1;
        checks++; if (memstall !== 1'b1) begin errors++; $display("FAIL read_stall_c0 got=%b exp=1", memstall); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL read_valid_c0 got=%b exp=0", bus_valid); end
        step();
        bus_ready = 1'b1;
        #1;
        checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL read_valid_c1 got=%b exp=1", bus_valid); end
        checks++; if (bus_addr !== 32'h8000_0010) begin errors++; $display("FAIL read_addr got=%h exp=80000010", bus_addr); end
        checks++; if (memstall !== 1'b1) begin errors++; $display("FAIL read_stall_c1 got=%b exp=1", memstall); end
        step();
        bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (memstall !== 1'b1) begin errors++; $display("FAIL read_stall_c2 got=%b exp=1", memstall); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL read_valid_c2 got=%b exp=0", bus_valid); end
        step();
        bus_rvalid = 1'b0; req[MEM] = 1'b0;
        #1;
        checks++; if (done_v !== 4'b0010) begin errors++; $display("FAIL read_done_c3 got=%b exp=0010", done_v); end
        checks++; if (rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rdata got=%h exp=deadbeef", rdata_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL read_err got=%b exp=0", err_o); end
        step();
        req[CTX] = 1'b1;
        #1;
        checks++; if (done_v !== 4'b0000) begin errors++; $display("FAIL read_done_c4 got=%b exp=0000", done_v); end
        step();
        #1;
        checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL read_rearb_c5 got=%b exp=1", bus_valid); end
    endtask

    task automatic test_priority();
        int order [3];
        logic [31:0] a, r; logic [3:0] d; logic e;
        order[0] = CTX; order[1] = HEAP; order[2] = IFR;
        apply_reset();
        req[CTX] = 1'b1; req[HEAP] = 1'b1; req[IFR] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_txn(order[k], 32'h100 + 32'(k), 1'b0, a, d, r, e);
            checks++;
            if (a !== addr[order[k]]) begin
                errors++; $display("FAIL prio_addr[%0d] got=%h exp=%h", k, a, addr[order[k]]);
            end
            checks++;
            if (d !== 4'(1 << order[k])) begin
                errors++; $display("FAIL prio_done[%0d] got=%b exp=%b", k, d, 4'(1 << order[k]));
            end
        end
    endtask

    // Second batch of 16 shows the counter restarted from zero after the fetch grant.
    task automatic test_starvation();
        logic [31:0] a, r; logic [3:0] d; logic e; int exp_id;
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            req[MEM] = 1'b1; req[IFR] = 1'b1;
            exp_id = (i == 15 || i == 31) ? IFR : MEM;
            run_txn(exp_id, 32'(i), 1'b0, a, d, r, e);
            checks++;
            if (d !== 4'(1 << exp_id)) begin
                errors++; $display("FAIL starve_done[%0d] got=%b exp=%b", i, d, 4'(1 << exp_id));
            end
            if (i == 15 || i == 31) begin
                checks++;
                if (a !== addr[IFR]) begin
                    errors++; $display("FAIL starve_addr[%0d] got=%h exp=%h", i, a, addr[IFR]);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] a, r; logic [3:0] d; logic e;
        apply_reset();
        req[IFR] = 1'b1; addr[IFR] = 32'h0000_4000;
        step();
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0; flushif = 1'b1;
        step();
        flushif = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
        step();
        bus_rvalid = 1'b0; req[IFR] = 1'b0;
        #1;
        checks++; if (done_v !== 4'b0000) begin errors++; $display("FAIL flush_done got=%b exp=0000", done_v); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", bus_valid); end
        step();
        req[MEM] = 1'b1;
        run_txn(MEM, 32'h3333_4444, 1'b0, a, d, r, e);
        checks++; if (d !== 4'b0010) begin errors++; $display("FAIL flush_next_done got=%b exp=0010", d); end
        checks++; if (r !== 32'h3333_4444) begin errors++; $display("FAIL flush_next_rdata got=%h exp=33334444", r); end
        flushif = 1'b1; req[MEM] = 1'b1;
        run_txn(MEM, 32'h5, 1'b0, a, d, r, e);
        flushif = 1'b0;
        checks++; if (d !== 4'b0010) begin errors++; $display("FAIL flush_other_done got=%b exp=0010", d); end
        req[IFR] = 1'b1;
        run_txn(IFR, 32'h6, 1'b0, a, d, r, e);
        checks++; if (d !== 4'b1000) begin errors++; $display("FAIL flush_cleared_done got=%b exp=1000", d); end
    endtask

    task automatic test_error();
        apply_reset();
        req[HEAP] = 1'b1; we[HEAP] = 1'b1; addr[HEAP] = 32'h2000_0008;
        wdata[HEAP] = 32'hA5A5_0F0F; wstrb[HEAP] = 4'b0110;
        step();
        bus_ready = 1'b1;
        #1;
        checks++; if (bus_we !== 1'b1) begin errors++; $display("FAIL err_we got=%b exp=1", bus_we); end
        checks++; if (bus_wdata !== 32'hA5A5_0F0F) begin errors++; $display("FAIL err_wdata got=%h exp=a5a50f0f", bus_wdata); end
        checks++; if (bus_wstrb !== 4'b0110) begin errors++; $display("FAIL err_wstrb got=%b exp=0110", bus_wstrb); end
        step();
        bus_ready = 1'b0; bus_rvalid = 1'b1; bus_err = 1'b1; bus_rdata = 32'h1234_5678;
        step();
        bus_rvalid = 1'b0; bus_err = 1'b0; req[HEAP] = 1'b0;
        #1;
        checks++; if (done_v !== 4'b0100) begin errors++; $display("FAIL err_done got=%b exp=0100", done_v); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_flag got=%b exp=1", err_o); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL err_rdata got=%h exp=0", rdata_o); end
    endtask

    task automatic test_reset_mid_resp();
        logic [3:0] seen;
        apply_reset();
        req[MEM] = 1'b1;
        step();
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0; rst = 1'b1; req[MEM] = 1'b0;
        step();
        rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        seen = done_v;
        #1;
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", bus_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            seen = seen | done_v;
        end
        bus_rvalid = 1'b0;
        checks++; if (seen !== 4'b0000) begin errors++; $display("FAIL rstmid_done got=%b exp=0000", seen); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid2 got=%b exp=0", bus_valid); end
        req[CTX] = 1'b1;
        step();
        #1;
        checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL rstmid_idle got=%b exp=1", bus_valid); end
        checks++; if (bus_addr !== addr[CTX]) begin errors++; $display("FAIL rstmid_addr got=%h exp=%h", bus_addr, addr[CTX]); end
    endtask

    // Model: a set of pending requesters; each grant is the lowest pending index unless the
    // fetch requester has already lost 15 arbitrations in a row.
    task automatic test_random();
        logic [3:0]  pend;
        int          model_starve, w, rdly, vdly;
        logic        x_we, e, flushed;
        logic [31:0] x_addr, x_wdata, rd;
        logic [3:0]  x_wstrb, exp_done;
        apply_reset();
        pend = '0;
        model_starve = 0;
        for (int t = 0; t < 150; t++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    we[i] = 1'($urandom); addr[i] = $urandom; wdata[i] = $urandom;
                    wstrb[i] = 4'($urandom);
                end
            end
            if (pend == 4'b0) pend[$urandom_range(0, 3)] = 1'b1;
            for (int i = 0; i < 4; i++) req[i] = pend[i];
            flushif = 1'($urandom_range(0, 3) == 0);
            #1;
            checks++; if (stall_v !== pend) begin errors++; $display("FAIL rnd_stall_idle[%0d] got=%b exp=%b", t, stall_v, pend); end

            if (model_starve == 15 && pend[IFR]) w = IFR;
            else if (pend[CTX]) w = CTX;
            else if (pend[MEM]) w = MEM;
            else if (pend[HEAP]) w = HEAP;
            else w = IFR;
            if (w == IFR) model_starve = 0;
            else if (pend[IFR] && model_starve < 15) model_starve++;

            x_we = we[w]; x_addr = addr[w]; x_wdata = wdata[w]; x_wstrb = wstrb[w];
            rdly = $urandom_range(0, 3); vdly = $urandom_range(0, 3);
            rd = $urandom; e = ($urandom_range(0, 3) == 0);
            flushed = 1'b0;
            step();

            for (int d = 0; d <= rdly; d++) begin
                bus_ready = (d == rdly); bus_rvalid = 1'($urandom);
                flushif = ($urandom_range(0, 7) == 0);
                if (flushif && w == IFR) flushed = 1'b1;
                we[w] = 1'($urandom); addr[w] = $urandom; wdata[w] = $urandom; wstrb[w] = 4'($urandom);
                #1;
                checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL rnd_valid[%0d] got=%b exp=1", t, bus_valid); end
                checks++;
                if ({bus_we, bus_addr, bus_wdata, bus_wstrb} !== {x_we, x_addr, x_wdata, x_wstrb}) begin
                    errors++;
                    $display("FAIL rnd_fields[%0d] got=%b/%h/%h/%h exp=%b/%h/%h/%h", t,
                             bus_we, bus_addr, bus_wdata, bus_wstrb, x_we, x_addr, x_wdata, x_wstrb);
                end
                step();
            end

            for (int d = 0; d <= vdly; d++) begin
                bus_ready = 1'($urandom); bus_rvalid = (d == vdly);
                bus_rdata = (d == vdly) ? rd : $urandom;
                bus_err = (d == vdly) ? e : 1'($urandom);
                flushif = ($urandom_range(0, 7) == 0);
                if (flushif && w == IFR) flushed = 1'b1;
                #1;
                checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL rnd_resp_valid[%0d] got=%b exp=0", t, bus_valid); end
                checks++; if (stall_v !== pend) begin errors++; $display("FAIL rnd_stall_resp[%0d] got=%b exp=%b", t, stall_v, pend); end
                step();
            end

            pend[w] = 1'b0; req[w] = 1'b0;
            bus_ready = 1'b0; bus_rvalid = 1'($urandom); bus_rdata = $urandom; bus_err = 1'($urandom);
            flushif = 1'($urandom);
            exp_done = flushed ? 4'b0000 : 4'(1 << w);
            #1;
            checks++; if (done_v !== exp_done) begin errors++; $display("FAIL rnd_done[%0d] got=%b exp=%b", t, done_v, exp_done); end
            checks++; if (rdata_o !== (e ? 32'h0 : rd)) begin errors++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", t, rdata_o, e ? 32'h0 : rd); end
            checks++; if (err_o !== e) begin errors++; $display("FAIL rnd_err[%0d] got=%b exp=%b", t, err_o, e); end
            checks++; if (stall_v !== pend) begin errors++; $display("FAIL rnd_stall_done[%0d] got=%b exp=%b", t, stall_v, pend); end
            step();
            bus_rvalid = 1'b0; bus_err = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_priority();
        test_starvation();
        test_flush();
        test_error();
        test_reset_mid_resp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
